uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe; one byte offered per asserted cycle.
REQ-006 din  input  8  byte to transmit, sampled when wr_en=1 and full=0.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes; writes are ignored while high.
REQ-008 empty  output  1  FIFO holds zero bytes.
REQ-009 busy  output  1  high while a frame (start, data or stop bit) is on the line.
REQ-010 tx  output  1  serial line, idle high, registered (glitch-free).

Function
REQ-011 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 Each bit SHALL be held for exactly CLKS_PER_BIT cycles; one frame = 10*CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1, busy=0; if the FIFO is non-empty, pop the head into the shift register and enter START on the next edge.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-016 DATA: tx=shift[index]; after CLKS_PER_BIT cycles, increment index; after index 7 completes, enter STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, if the FIFO is non-empty, pop and enter START directly (back-to-back, no idle gap); otherwise enter IDLE.
REQ-018 Latency: with the FIFO empty and the FSM in IDLE, wr_en at edge k SHALL drive tx low from edge k+2.
REQ-019 The write is accepted iff wr_en=1 and full=0 at the edge; a rejected write is silently dropped, and stored data and count are unchanged.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-021 When full=1, a same-cycle pop does not unblock that cycle's write; full is decoded from the registered count.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count register width is clog2(FIFO_DEPTH)+1.
REQ-023 din changes after acceptance SHALL NOT affect a queued or in-flight byte.
REQ-024 The baud counter SHALL restart at 0 on every bit boundary and state entry, with no cumulative drift.

Reset
REQ-025 rst_n=0 SHALL immediately force tx=1, busy=0, empty=1, full=0, state=IDLE, counters/pointers/index=0, independent of clk.
REQ-026 Reset mid-frame SHALL abort the frame, discard all FIFO contents, and return tx high within the same cycle.
REQ-027 After rst_n rises, the first wr_en SHALL be accepted on the first clock edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte: write 0xA5 from idle -> tx low at k+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; busy high for 40 cycles total.
REQ-029 Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit; empty=1 after the second pop.
REQ-030 Overflow: 6 consecutive writes 0x01..0x06 while idle -> 0x01 is popped immediately and 0x02..0x05 fill the FIFO; full=1 and 0x06 is dropped; line carries exactly 0x01..0x05 in order.
REQ-031 Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 and busy=0 asynchronously; no further frames after release.
REQ-032 Push and pop when full: FIFO full, STOP ending, wr_en=1 with 0x77 -> write rejected, count goes 4->3, full=0 next cycle; a retry of 0x77 is accepted and transmitted last.
REQ-033 Wrap-around: stream 12 bytes with throttled writes (write only when full=0) -> all 12 received in order; pointers wrap 3 times with no loss.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- FIFO-buffered 8N1 UART transmitter.
//
// Bytes written through wr_en/din land in a small circular FIFO. A four-state
// FSM (IDLE, START, DATA, STOP) pops the head into a shift register and sends
// it as 1 start bit, 8 data bits LSB first and 1 stop bit. Each bit lasts
// CLKS_PER_BIT clocks. A byte that is waiting when a stop bit ends is sent
// straight after it, with no idle cycle.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit, 2..65535
//   FIFO_DEPTH    FIFO entries, power of two, 2..16
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any frame and flushes the FIFO
//   wr_en  write strobe; one byte per asserted cycle
//   din    byte to send, taken when wr_en=1 and full=0
//   full   FIFO holds FIFO_DEPTH bytes; writes are dropped while high
//   empty  FIFO holds no bytes
//   busy   a frame is on the line
//   tx     serial output, idles high, driven from a flop
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Transmit FIFO
  // --------------------------------------------------------------------------
  logic [FIFO_DEPTH-1:0][7:0] mem_q;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]          count_q, count_d;
  logic                       push, pop;
  logic [7:0]                 head;

  // full comes from the registered count. A pop in the same cycle therefore
  // does not make room for that cycle's write.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign head  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= din;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             bit_end;

  assign bit_end = (baud_q == BIT_LAST);

  // Pop when leaving IDLE, or when a stop bit ends and another byte is waiting.
  // The pop and the shift-register load happen on the same edge.
  assign pop = !empty && ((state_q == IDLE) || (state_q == STOP && bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      // tx and busy are registered copies of the current state. Both lag the
      // state by exactly one cycle. That lag gives the write-to-start latency
      // of two edges, and each bit still lasts CLKS_PER_BIT cycles on the line.
      case (state_q)
        IDLE:    begin tx_q <= 1'b1;           busy_q <= 1'b0; end
        START:   begin tx_q <= 1'b0;           busy_q <= 1'b1; end
        DATA:    begin tx_q <= shift_q[idx_q]; busy_q <= 1'b1; end
        STOP:    begin tx_q <= 1'b1;           busy_q <= 1'b1; end
        default: begin tx_q <= 1'b1;           busy_q <= 1'b0; end
      endcase

      // The baud counter restarts from zero at every bit boundary, so no
      // error builds up across bits or across frames.
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          idx_q  <= '0;
          if (pop) begin
            shift_q <= head;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q  <= baud_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            idx_q  <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            idx_q  <= '0;
            if (pop) begin
              shift_q <= head;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
